// File: rtl/regfile.sv
// Two-read, one-write register file with entry 0 hardwired to zero and combinational read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read port.
module regfile #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [4:0]        raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [4:0]        raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [REG_NUM];
  logic              wr_ok;

  // Address 0 and addresses beyond REG_NUM never hold state.
  assign wr_ok = we && (waddr != 5'd0) && (32'(waddr) < REG_NUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (!rst && re1 && (raddr1 != 5'd0) && (32'(raddr1) < REG_NUM)) begin
`ifdef REGFILE_BYPASS_EN
      if (we && (raddr1 == waddr)) begin
        rdata1 = wdata;
      end else begin
        rdata1 = mem[raddr1];
      end
`else
      rdata1 = mem[raddr1];
`endif
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && re2 && (raddr2 != 5'd0) && (32'(raddr2) < REG_NUM)) begin
`ifdef REGFILE_BYPASS_EN
      if (we && (raddr2 == waddr)) begin
        rdata2 = wdata;
      end else begin
        rdata2 = mem[raddr2];
      end
`else
      rdata2 = mem[raddr2];
`endif
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Testbench for regfile: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against an array-based reference model.
module tb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = 5'd0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = 5'd0;
  logic [31:0] rdata2;

  int checks = 0;
  int passes = 0;

  logic [31:0] ref_mem [32];

  regfile #(.DATA_W(32), .REG_NUM(32)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: plain array, cleared by reset, entry 0 never written.
  initial for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'd0;
    end else if (we && waddr != 5'd0) begin
      ref_mem[waddr] = wdata;
    end
  end

  function automatic logic [31:0] model_read(input logic ren, input logic [4:0] ra);
    if (rst || !ren || ra == 5'd0) return 32'd0;
    if (BYP && we && ra == waddr) return wdata;
    return ref_mem[ra];
  endfunction

  always @(negedge clk) begin
    chk("model_rdata1", rdata1, model_read(re1, raddr1));
    chk("model_rdata2", rdata2, model_read(re2, raddr2));
  end

  task automatic cyc(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    @(negedge clk);
  endtask

  initial begin
    // Write attempted while held in reset, then read after release
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd5;
    @(negedge clk);
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    cyc(1, 1, 5, 32'hDEADBEEF, 1, 5, 1, 5);
    chk("rst_hold_rdata1", rdata1, 32'h0);
    cyc(0, 0, 0, 0, 1, 5, 0, 0);
    chk("post_rst_read5", rdata1, 32'h0);

    // Write then dual-port read of the same address
    cyc(0, 1, 3, 32'h12345678, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 3, 1, 3);
    chk("dual_rdata1", rdata1, 32'h12345678);
    chk("dual_rdata2", rdata2, 32'h12345678);

    // Write to address 0 is discarded
    cyc(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 0);
    chk("zero_reg", rdata1, 32'h0);

    // Same-cycle read/write of entry 7
    cyc(0, 1, 7, 32'hA, 0, 0, 0, 0);
    cyc(0, 1, 7, 32'hB, 0, 0, 1, 7);
    chk("rw_same_cycle", rdata2, BYP ? 32'hB : 32'hA);
    cyc(0, 0, 0, 0, 0, 0, 1, 7);
    chk("rw_next_cycle", rdata2, 32'hB);

    // Read enable gating and reset clearing of entry 9
    cyc(0, 1, 9, 32'h55, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 9, 0, 0);
    chk("re_low", rdata1, 32'h0);
    cyc(0, 0, 0, 0, 1, 9, 0, 0);
    chk("read9", rdata1, 32'h55);
    cyc(1, 0, 0, 0, 1, 9, 0, 0);
    chk("read9_in_rst", rdata1, 32'h0);
    cyc(0, 0, 0, 0, 1, 9, 0, 0);
    chk("read9_after_rst", rdata1, 32'h0);

    // Back-to-back writes to entry 31
    cyc(0, 1, 31, 32'h1, 0, 0, 0, 0);
    cyc(0, 1, 31, 32'h2, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 31, 0, 0);
    chk("last_write_wins", rdata1, 32'h2);

    // Read and write at different addresses do not interact
    cyc(0, 1, 4, 32'hCAFE0004, 1, 31, 0, 0);
    chk("rw_diff_addr", rdata1, 32'h2);

    // Randomized traffic, biased toward read/write address collisions
    for (int n = 0; n < 3000; n++) begin
      logic        r, w, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      w  = ($urandom_range(0, 2) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      e1 = ($urandom_range(0, 4) != 0);
      e2 = ($urandom_range(0, 4) != 0);
      a1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      cyc(r, w, wa, wd, e1, a1, e2, a2);
    end

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
